mult_booth_ctrl: RTL
====================

// Module: mult_booth_ctrl
// PURPOSE
//  Radix-2 Booth multiply sequencer for the CPU's multiply unit. It does not contain an adder.
//  Each step it drives operands into the shared 32-bit CLA adder (8-bit CLA groups, also used by the ALU).
//  An external arbiter owns that adder. This block requests it, stalls when not granted, and returns a 32-bit product with an overflow flag.
// PARAMETERS
//  WIDTH   32   operand/result width; also the Booth step count
// PORTS
//  clock           in   1      single clock, rising edge
//  reset_n         in   1      asynchronous, active-low reset
//  ctrl_MULT       in   1      start pulse; samples data_operandA/B
//  data_operandA   in   WIDTH  multiplicand M (two's complement)
//  data_operandB   in   WIDTH  multiplier Q (two's complement)
//  add_req         out  1      request for the shared adder
//  add_gnt         in   1      grant; the step executes only on an edge with add_req&add_gnt
//  add_a           out  WIDTH  adder operand A = accumulator
//  add_b           out  WIDTH  adder operand B = M, ~M or 0
//  add_cin         out  1      adder carry-in (1 only for subtract)
//  add_sum         in   WIDTH  adder sum, combinational from add_a/add_b/add_cin
//  data_result     out  WIDTH  low WIDTH bits of the product
//  data_exception  out  1      product overflow flag (see CONFIGURATION)
//  data_resultRDY  out  1      one-cycle result-valid pulse
//  busy            out  1      high in RUN and DONE
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE. All outputs=0, ACC=0, count=0. Holding registers M/Q/q_1 cleared.
//  States: IDLE -> RUN on ctrl_MULT. RUN -> DONE after WIDTH granted steps. DONE -> IDLE after 1 cycle.
//  Start in IDLE/DONE/RUN (same edge): latch M=A, Q=B, q_1=0, ACC=0, count=0, state=RUN.
//   Clear data_resultRDY and data_exception. Starting in RUN aborts the current op silently; no RDY pulse for it.
//  RUN: add_req=1 and add_a=ACC. Booth pair {Q[0],q_1} selects add_b/add_cin:
//   01 gives M/0. 10 gives ~M/1. 00 or 11 gives 0/0.
//  Granted edge: ovf = (add_a[W-1]==add_b[W-1]) & (add_sum[W-1]!=add_a[W-1]); s = add_sum[W-1]^ovf.
//   Then {ACC,Q,q_1} <= {s, add_sum, Q} >> 1 (arithmetic shift by one), and count++.
//  Edge with add_req & ~add_gnt: no register changes (stall), operands held stable; count does not advance.
//  Step WIDTH (count==WIDTH-1 granted): state=DONE; data_result<=shifted Q; data_resultRDY<=1.
//  DONE: add_req=0. data_resultRDY falls on the next edge. data_result/exception hold until the next start.
//  Latency, no stalls: data_resultRDY high exactly in the cycle after edge WIDTH (start edge = edge 0).
//   Each denied grant adds one cycle.
//  Outside RUN: add_a/add_b/add_cin=0, add_req=0.
//  Reset mid-RUN: immediate abort to IDLE; no RDY pulse.
//  Operands -2^(W-1) are legal; the sign fix-up via ovf keeps the accumulator exact.
// CONFIGURATION
//  Macro MULT_OVF_EN defined: data_exception<=1 at step WIDTH if the final ACC is not all copies of result bit W-1.
//   That means the 2W-bit product does not fit in W bits. The flag is registered alongside data_result.
//  Undefined: data_exception tied 0; no overflow logic synthesised.
// STRUCTURE
//  Shared package mult_pkg: WIDTH default, state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), Booth-pair codes.
//  One sub-module: mult_step_counter (clog2(WIDTH)-bit counter).
//   Ports: clear, enable (=add_req&add_gnt); output last (count==WIDTH-1).
//  Adder and arbiter stay outside this block.
// TESTING (bench models add_sum = add_a+add_b+add_cin, mod 2^W)
//  A=3, B=5, add_gnt=1 -> data_result=15, exception=0, RDY pulse in the cycle after edge 32, busy low after.
//  A=-7, B=6 -> result=0xFFFFFFD6 (-42), exception=0. A=0x80000000, B=-1 -> result=0x80000000.
//   Exception=1 with MULT_OVF_EN, 0 without.
//  A=3, B=5 with add_gnt low for 4 cycles mid-run -> result 15; RDY 4 cycles later than the no-stall case.
//   add_a/add_b/add_cin held stable while stalled.
//  A=3, B=5, then restart at step 10 with A=2, B=9 -> exactly one RDY pulse, result=18.
//  reset_n low at step 16 -> all outputs 0 at once, state IDLE. The next op A=-1, B=-1 gives result=1.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the Booth multiply sequencer: default width, FSM encoding and
// Booth-pair codes.
package mult_pkg;

    localparam int unsigned MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } mult_state_t;

    // {Q[0], q_1} pairs that need an add or a subtract; 00/11 add zero.
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/mult_step_counter.sv
// Booth step counter: counts granted steps and flags the last one (count == WIDTH-1).
module mult_step_counter
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign last = (r_count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_booth_ctrl.sv
// Radix-2 Booth multiply sequencer driving an external shared adder.
// Define MULT_OVF_EN to register a product-overflow flag on data_exception.
module mult_booth_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             add_req,
    input  logic             add_gnt,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    mult_state_t      r_state, w_state_next;
    logic [WIDTH-1:0] r_m, r_q, r_acc, r_result;
    logic             r_q1, r_rdy;
    logic             w_step, w_last, w_ovf, w_s;
    logic [WIDTH-1:0] w_acc_next, w_q_next;

    assign w_step = add_req & add_gnt;

    mult_step_counter #(.WIDTH(WIDTH)) u_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (ctrl_MULT),
        .enable  (w_step),
        .last    (w_last)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= StIdle;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (ctrl_MULT) begin
            w_state_next = StRun;
        end else begin
            case (r_state)
                StRun:   if (w_step && w_last) w_state_next = StDone;
                StDone:  w_state_next = StIdle;
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_comb begin
        add_req = 1'b0;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        busy    = (r_state != StIdle);
        if (r_state == StRun) begin
            add_req = 1'b1;
            add_a   = r_acc;
            case ({r_q[0], r_q1})
                BOOTH_ADD: add_b = r_m;
                BOOTH_SUB: begin
                    add_b   = ~r_m;
                    add_cin = 1'b1;
                end
                default:   add_b = '0;
            endcase
        end
    end

    // Recover the true sign of the (WIDTH+1)-bit sum so M = -2^(W-1) stays exact.
    assign w_ovf      = (add_a[WIDTH-1] == add_b[WIDTH-1]) & (add_sum[WIDTH-1] != add_a[WIDTH-1]);
    assign w_s        = add_sum[WIDTH-1] ^ w_ovf;
    assign w_acc_next = {w_s, add_sum[WIDTH-1:1]};
    assign w_q_next   = {add_sum[0], r_q[WIDTH-1:1]};

`ifdef MULT_OVF_EN
    logic r_exc;
    assign data_exception = r_exc;
`else
    assign data_exception = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_m      <= '0;
            r_q      <= '0;
            r_q1     <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
            r_rdy    <= 1'b0;
`ifdef MULT_OVF_EN
            r_exc    <= 1'b0;
`endif
        end else if (ctrl_MULT) begin
            r_m   <= data_operandA;
            r_q   <= data_operandB;
            r_q1  <= 1'b0;
            r_acc <= '0;
            r_rdy <= 1'b0;
`ifdef MULT_OVF_EN
            r_exc <= 1'b0;
`endif
        end else begin
            r_rdy <= 1'b0;
            if (w_step) begin
                r_acc <= w_acc_next;
                r_q   <= w_q_next;
                r_q1  <= r_q[0];
                if (w_last) begin
                    r_result <= w_q_next;
                    r_rdy    <= 1'b1;
`ifdef MULT_OVF_EN
                    r_exc    <= (w_acc_next != {WIDTH{w_q_next[WIDTH-1]}});
`endif
                end
            end
        end
    end

    assign data_result    = r_result;
    assign data_resultRDY = r_rdy;

endmodule
